// File: rtl/gcd_datapath.sv
// Datapath for a subtractive-Euclid GCD engine. An external controller sequences the X/Y
// registers; host-side operand and result buffers each hold one entry, with sticky misuse flags.
module gcd_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         op_valid,
  input  logic         x_load,
  input  logic         y_load,
  input  logic         x_sel,
  input  logic         y_sel,
  input  logic         gcd_load,
  output logic         eq_flag,
  output logic         if_flag,
  output logic         zero_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] gcd_out,
  output logic         err_underrun,
  output logic         err_overrun
);

  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic         op_full_q, op_full_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic [W-1:0] gcd_q, gcd_d;
  logic         out_valid_q, out_valid_d;
  logic         err_underrun_q, err_underrun_d;
  logic         err_overrun_q, err_overrun_d;

  logic capture, consume;

  assign in_ready = !op_full_q;
  assign op_valid = op_full_q;
  assign capture  = in_valid && !op_full_q;
  assign consume  = (x_load && !x_sel) || (y_load && !y_sel);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_full_d      = op_full_q;
    x_d            = x_q;
    y_d            = y_q;
    gcd_d          = gcd_q;
    out_valid_d    = out_valid_q;
    err_underrun_d = err_underrun_q;
    err_overrun_d  = err_overrun_q;

    // A load from an empty buffer still takes the stale operands but is flagged.
    if (consume) begin
      op_full_d = 1'b0;
      if (!op_full_q) err_underrun_d = 1'b1;
    end
    if (capture) begin
      op_a_d    = a_in;
      op_b_d    = b_in;
      op_full_d = 1'b1;
    end

    // Both subtractions read the pre-edge X and Y, so simultaneous updates are parallel.
    if (x_load) x_d = x_sel ? (x_q - y_q) : op_a_q;
    if (y_load) y_d = y_sel ? (y_q - x_q) : op_b_q;

    if (gcd_load) begin
      gcd_d       = x_q;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) err_overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_full_q      <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      gcd_q          <= '0;
      out_valid_q    <= 1'b0;
      err_underrun_q <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_full_q      <= op_full_d;
      x_q            <= x_d;
      y_q            <= y_d;
      gcd_q          <= gcd_d;
      out_valid_q    <= out_valid_d;
      err_underrun_q <= err_underrun_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  assign eq_flag      = (x_q == y_q);
  assign if_flag      = (x_q < y_q);
  assign zero_op      = (x_q == '0) || (y_q == '0);
  assign out_valid    = out_valid_q;
  assign gcd_out      = gcd_q;
  assign err_underrun = err_underrun_q;
  assign err_overrun  = err_overrun_q;

endmodule
